rv32i_idtop: RTL and testbench

// - RV32I instruction-decode stage; sits directly downstream of fetch, upstream of execute.
// - Takes the fetched instruction word and its PC, reads the register file, and resolves JAL/JALR/branches.
// - Returns the jump request and jump target to fetch, and registers decoded operands into the ID/EX pipeline register.
// - Squashes the one wrong-path instruction that follows a taken jump.

---
 rtl/rv32i_pkg.sv | 47 ++++
 rtl/rv32i_regfile.sv | 39 +++
 rtl/rv32i_idtop.sv | 154 +++++++++++++++
 tb/tb_rv32i_idtop.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I decode constants, immediate formats and format lookup
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RIDX  = $clog2(NREGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] NOP_IW = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
    case (opcode)
      OP_JALR, OP_LOAD, OP_IMM: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// rtl/rv32i_regfile.sv - 2R1W register file, x0 hardwired to zero, write-through bypass
module rv32i_regfile
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic [RIDX-1:0] wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [RIDX-1:0] rs1_addr_i,
  input  logic [RIDX-1:0] rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A write landing this cycle is forwarded so decode sees the value WB is committing.
  always_comb begin
    rs1_data_o = mem_q[rs1_addr_i];
    if (rs1_addr_i == '0) rs1_data_o = '0;
    else if (wr_en_i && (wr_addr_i == rs1_addr_i)) rs1_data_o = wr_data_i;
  end

  always_comb begin
    rs2_data_o = mem_q[rs2_addr_i];
    if (rs2_addr_i == '0) rs2_data_o = '0;
    else if (wr_en_i && (wr_addr_i == rs2_addr_i)) rs2_data_o = wr_data_i;
  end

endmodule

// File: rtl/rv32i_idtop.sv
// rtl/rv32i_idtop.sv - RV32I decode stage: regfile read, jump resolution, squash, ID/EX register
module rv32i_idtop
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] iw_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            jump_en_in,
  input  logic            wb_en_in,
  input  logic [RIDX-1:0] wb_reg_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic            jump_en_out,
  output logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] iw_out,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [XLEN-1:0] imm_out,
  output logic            wb_en_out,
  output logic [RIDX-1:0] wb_reg_out
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RIDX-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_val, target;
  logic            br_taken, jump_req, writes_rd;

  assign opcode  = iw_in[6:0];
  assign rd_idx  = iw_in[11:7];
  assign funct3  = iw_in[14:12];
  assign rs1_idx = iw_in[19:15];
  assign rs2_idx = iw_in[24:20];

  rv32i_regfile u_regfile (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (wb_en_in),
    .wr_addr_i  (wb_reg_in),
    .wr_data_i  (wb_data_in),
    .rs1_addr_i (rs1_idx),
    .rs2_addr_i (rs2_idx),
    .rs1_data_o (rs1_val),
    .rs2_data_o (rs2_val)
  );

  always_comb begin
    imm_val = '0;
    case (imm_fmt(opcode))
      IMM_I:   imm_val = {{20{iw_in[31]}}, iw_in[31:20]};
      IMM_S:   imm_val = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
      IMM_B:   imm_val = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
      IMM_U:   imm_val = {iw_in[31:12], 12'b0};
      IMM_J:   imm_val = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};
      default: imm_val = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    jump_req = 1'b0;
    target   = '0;
    case (opcode)
      OP_JAL: begin
        jump_req = 1'b1;
        target   = pc_in + imm_val;
      end
      OP_JALR: begin
        jump_req = 1'b1;
        target   = rs1_val + imm_val;
      end
      OP_BRANCH: begin
        jump_req = br_taken;
        target   = pc_in + imm_val;
      end
      default: ;
    endcase
  end

  // A wrong-path word may itself look like a jump; it must never redirect fetch.
  assign jump_en_out = jump_req & ~reset & ~jump_en_in;
  assign jump_addr   = jump_en_out ? (target & {{(XLEN-1){1'b1}}, 1'b0}) : '0;

  always_comb begin
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP: writes_rd = (rd_idx != '0);
      default:                                                  writes_rd = 1'b0;
    endcase
  end

  logic [XLEN-1:0] pc_d, pc_q, iw_d, iw_q, rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q;
  logic            wb_en_d, wb_en_q;
  logic [RIDX-1:0] wb_reg_d, wb_reg_q;

  always_comb begin
    pc_d     = pc_in;
    iw_d     = iw_in;
    rs1_d    = rs1_val;
    rs2_d    = rs2_val;
    imm_d    = imm_val;
    wb_en_d  = writes_rd;
    wb_reg_d = writes_rd ? rd_idx : '0;
    if (jump_en_in) begin
      iw_d     = NOP_IW;
      rs1_d    = '0;
      rs2_d    = '0;
      imm_d    = '0;
      wb_en_d  = 1'b0;
      wb_reg_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      iw_q     <= NOP_IW;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      wb_en_q  <= 1'b0;
      wb_reg_q <= '0;
    end else begin
      pc_q     <= pc_d;
      iw_q     <= iw_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      wb_en_q  <= wb_en_d;
      wb_reg_q <= wb_reg_d;
    end
  end

  assign pc_out       = pc_q;
  assign iw_out       = iw_q;
  assign rs1_data_out = rs1_q;
  assign rs2_data_out = rs2_q;
  assign imm_out      = imm_q;
  assign wb_en_out    = wb_en_q;
  assign wb_reg_out   = wb_reg_q;

endmodule

// File: tb/tb_rv32i_idtop.sv
// tb/tb_rv32i_idtop.sv - directed and randomized checks of rv32i_idtop against a behavioural model
module tb_rv32i_idtop;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iw_in, pc_in, wb_data_in;
  logic        jump_en_in, wb_en_in;
  logic [4:0]  wb_reg_in;
  logic        jump_en_out, wb_en_out;
  logic [31:0] jump_addr, pc_out, iw_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]  wb_reg_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_idtop dut (
    .clk          (clk),
    .reset        (reset),
    .iw_in        (iw_in),
    .pc_in        (pc_in),
    .jump_en_in   (jump_en_in),
    .wb_en_in     (wb_en_in),
    .wb_reg_in    (wb_reg_in),
    .wb_data_in   (wb_data_in),
    .jump_en_out  (jump_en_out),
    .jump_addr    (jump_addr),
    .pc_out       (pc_out),
    .iw_out       (iw_out),
    .rs1_data_out (rs1_data_out),
    .rs2_data_out (rs2_data_out),
    .imm_out      (imm_out),
    .wb_en_out    (wb_en_out),
    .wb_reg_out   (wb_reg_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mreg [32];
  logic [31:0] exp_pc = 0, exp_iw = 32'h13, exp_rs1 = 0, exp_rs2 = 0, exp_imm = 0;
  logic        exp_wben = 0;
  logic [4:0]  exp_wbreg = 0;
  logic        exp_squash = 0;
  logic        last_jump = 0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_en_in && wb_reg_in == a) return wb_data_in;
    return mreg[a];
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] iw);
    case (iw[6:0])
      7'h37, 7'h17:        return iw & 32'hFFFF_F000;
      7'h67, 7'h03, 7'h13: return 32'($signed(iw) >>> 20);
      7'h23:               return (32'($signed(iw) >>> 20) & ~32'd31) | 32'(iw[11:7]);
      7'h63:               return {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
      7'h6F:               return {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
      default:             return 0;
    endcase
  endfunction

  initial for (int i = 0; i < 32; i++) mreg[i] = 0;

  always @(negedge clk) begin
    logic [31:0] r1, r2, imm, tgt;
    logic        taken, wr;
    chk("pc_out", pc_out, exp_pc);
    chk("iw_out", iw_out, exp_iw);
    chk("wb_en_out", 32'(wb_en_out), 32'(exp_wben));
    chk("wb_reg_out", 32'(wb_reg_out), 32'(exp_wbreg));
    if (!exp_squash) begin
      chk("rs1_data_out", rs1_data_out, exp_rs1);
      chk("rs2_data_out", rs2_data_out, exp_rs2);
      chk("imm_out", imm_out, exp_imm);
    end

    r1 = m_read(iw_in[19:15]);
    r2 = m_read(iw_in[24:20]);
    imm = m_imm(iw_in);
    taken = 0;
    tgt = 0;
    case (iw_in[6:0])
      7'h6F: begin taken = 1; tgt = pc_in + imm; end
      7'h67: begin taken = 1; tgt = r1 + imm; end
      7'h63: begin
        tgt = pc_in + imm;
        case (iw_in[14:12])
          3'd0: taken = (r1 == r2);
          3'd1: taken = (r1 != r2);
          3'd4: taken = ($signed(r1) < $signed(r2));
          3'd5: taken = ($signed(r1) >= $signed(r2));
          3'd6: taken = (r1 < r2);
          3'd7: taken = (r1 >= r2);
          default: taken = 0;
        endcase
      end
      default: ;
    endcase
    if (reset || jump_en_in) taken = 0;
    chk("jump_en_out", 32'(jump_en_out), 32'(taken));
    chk("jump_addr", jump_addr, taken ? (tgt & ~32'd1) : 32'd0);
    last_jump = taken;

    wr = (iw_in[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (iw_in[11:7] != 0);
    if (reset) begin
      exp_pc = 0; exp_iw = 32'h13; exp_rs1 = 0; exp_rs2 = 0; exp_imm = 0;
      exp_wben = 0; exp_wbreg = 0; exp_squash = 0;
      for (int i = 0; i < 32; i++) mreg[i] = 0;
    end else begin
      exp_pc = pc_in;
      exp_squash = jump_en_in;
      exp_iw    = jump_en_in ? 32'h13 : iw_in;
      exp_wben  = !jump_en_in && wr;
      exp_wbreg = exp_wben ? iw_in[11:7] : 5'd0;
      exp_rs1 = r1; exp_rs2 = r2; exp_imm = imm;
      if (wb_en_in && wb_reg_in != 0) mreg[wb_reg_in] = wb_data_in;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic comb_chk(input string name, input logic en, input logic [31:0] addr);
    #2;
    chk({name, "_en"}, 32'(jump_en_out), 32'(en));
    chk({name, "_addr"}, jump_addr, addr);
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_en_in = en; wb_reg_in = r; wb_data_in = d;
  endtask

  logic [6:0]  ops [12];
  logic [31:0] vals [6];

  initial begin
    reset = 1; iw_in = 32'h0100006F; pc_in = 0; jump_en_in = 0;
    wb(0, 0, 0);
    #3 chk("rst0_jump", 32'(jump_en_out), 0);
    next_cycle();
    #2 chk("rst1_jump", 32'(jump_en_out), 0);
    next_cycle();
    chk("rst_iw", iw_out, 32'h13);
    chk("rst_pc", pc_out, 0);
    chk("rst_rs1", rs1_data_out, 0);
    chk("rst_imm", imm_out, 0);
    chk("rst_wben", 32'(wb_en_out), 0);

    reset = 0; pc_in = 32'h100; iw_in = 32'h0100006F;
    comb_chk("jal", 1, 32'h110);
    next_cycle();
    chk("jal_iw", iw_out, 32'h0100006F);
    chk("jal_rd0_wben", 32'(wb_en_out), 0);
    jump_en_in = 1; iw_in = 32'h00500093; pc_in = 32'h104;
    comb_chk("squash", 0, 0);
    next_cycle();
    chk("squash_iw", iw_out, 32'h13);
    chk("squash_wben", 32'(wb_en_out), 0);
    jump_en_in = 0; iw_in = 32'h13; wb(1, 1, 5);
    next_cycle(); wb(1, 2, 5);
    next_cycle(); wb(0, 0, 0); iw_in = 32'hFE208CE3; pc_in = 32'h200;
    comb_chk("beq_t", 1, 32'h1F8);
    next_cycle(); jump_en_in = 1; iw_in = 32'h13; wb(1, 2, 6);
    next_cycle(); jump_en_in = 0; wb(0, 0, 0); iw_in = 32'hFE208CE3;
    comb_chk("beq_nt", 0, 0);
    next_cycle(); iw_in = 32'h13; wb(1, 1, 32'hFFFF_FFFF);
    next_cycle(); wb(1, 2, 1);
    next_cycle(); wb(0, 0, 0); iw_in = 32'hFE20CCE3; pc_in = 32'h300;
    comb_chk("blt", 1, 32'h2F8);
    next_cycle(); jump_en_in = 1; iw_in = 32'h13;
    next_cycle(); jump_en_in = 0; iw_in = 32'hFE20ECE3;
    comb_chk("bltu", 0, 0);
    next_cycle(); iw_in = 32'h003280E7; pc_in = 32'h400; wb(1, 5, 32'h1003);
    comb_chk("jalr_byp", 1, 32'h1006);
    next_cycle();
    chk("jalr_wben", 32'(wb_en_out), 1);
    chk("jalr_wbreg", 32'(wb_reg_out), 1);
    jump_en_in = 1; iw_in = 32'h13; wb(0, 0, 0);
    next_cycle(); jump_en_in = 0; iw_in = 32'h000001B3; wb(1, 0, 32'hDEAD);
    next_cycle();
    chk("x0_byp_rs1", rs1_data_out, 0);
    chk("add_wbreg", 32'(wb_reg_out), 3);
    wb(0, 0, 0);
    next_cycle();
    chk("x0_rs1", rs1_data_out, 0);

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    for (int n = 0; n < 3000; n++) begin
      vals = '{32'd0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, $urandom};
      next_cycle();
      reset = ($urandom_range(0, 99) == 0);
      jump_en_in = last_jump;
      iw_in = $urandom;
      iw_in[6:0] = ops[$urandom_range(0, 11)];
      iw_in[19:15] = 5'($urandom_range(0, 3));
      iw_in[24:20] = 5'($urandom_range(0, 3));
      pc_in = $urandom & ~32'd3;
      wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)), vals[$urandom_range(0, 5)]);
    end
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
